weighted_rr_arbiter: RTL and testbench

//  N-requester weighted round-robin arbiter with registered one-hot grant and
//  per-requester credit. A winner holds the shared resource for up to weight[i]

---
 rtl/weighted_rr_arbiter_pkg.sv | 19 +
 rtl/weighted_rr_arbiter_rr_pick.sv | 47 ++++
 rtl/weighted_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_weighted_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared definitions for the weighted round-robin arbiter: default sizing,
// FSM state encoding and an index-width helper.
package weighted_rr_arbiter_pkg;

    localparam int N_DEFAULT  = 8;
    localparam int WW_DEFAULT = 4;

    // Arbiter FSM: IDLE waits for any request, BUSY holds a tenure.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Width of a binary requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weighted_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// after ptr_i, wrapping around, as both a one-hot vector and a binary index.
module weighted_rr_arbiter_rr_pick
    import weighted_rr_arbiter_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    localparam int W2 = 2 * N;

    logic [W2-1:0] dreq;
    logic [W2-1:0] prio;
    logic [W2-1:0] gnt2;

    // Doubling the vector turns the wrap-around search into a plain
    // "lowest set bit at or above prio" which the subtract trick isolates.
    assign dreq = {req_i, req_i};
    assign prio = {{(W2-1){1'b0}}, 1'b1} << ptr_i;
    assign gnt2 = dreq & ~(dreq - prio);

    // Fold the upper copy back onto the lower one; only one bit can be set.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fold
            assign onehot_o[gi] = gnt2[gi] | gnt2[gi + N];
        end
    endgenerate

    assign any_o = |req_i;

    // One-hot to binary encode of the winner.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot_o[i]) begin
                idx_o = idx_o | IW'(i);
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// N-requester weighted round-robin arbiter. A winner keeps the registered
// one-hot grant for up to its weight in beats (or packets in PKT_MODE), then
// priority rotates to the requester after it, with no idle bubble between
// back-to-back tenures.
module weighted_rr_arbiter
    import weighted_rr_arbiter_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int WW       = WW_DEFAULT,
    parameter int PKT_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    input  logic [N*WW-1:0]      weight,
    input  logic                 ready,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_vld,
    output logic                 beat
);

    localparam int IW = idx_w(N);

    state_e        state_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gnt_idx_q;
    logic [IW-1:0] ptr_q;
    logic [WW-1:0] credit_q;
    logic          pkt_open_q;

    logic [WW-1:0] weight_arr [N];

    logic          g_req;
    logic          g_last;
    logic          beat_w;
    logic          credit_dec;
    logic          rel_credit;
    logic          rel_drop;
    logic          release_w;
    logic          load_w;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  pick_req;
    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [WW-1:0] pick_weight;
    logic [WW-1:0] load_credit;

    // Unpack the flat weight bus so the winner's field can be indexed directly.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_weight
            assign weight_arr[gi] = weight[gi*WW +: WW];
        end
    endgenerate

    assign g_req  = req[gnt_idx_q];
    assign g_last = last[gnt_idx_q];

    // gnt is all-zero when idle, so this also gates beats to BUSY only.
    assign beat_w = (|(gnt_q & req)) & ready;

    // Credit is spent per beat, or per completed packet in PKT_MODE.
    assign credit_dec = beat_w & ((PKT_MODE == 0) | g_last);
    assign rel_credit = credit_dec & (credit_q == WW'(1));

    // Owner went away; in PKT_MODE an open packet keeps the grant through the gap.
    assign rel_drop  = (state_q == BUSY) & ~g_req & ((PKT_MODE == 0) | ~pkt_open_q);
    assign release_w = rel_credit | rel_drop;

    assign next_ptr = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + IW'(1);

    // On release the search starts just past the current owner, so the owner
    // itself only wins again when nobody else is asking.
    assign pick_ptr = (state_q == BUSY) ? next_ptr : ptr_q;
    assign pick_req = rel_drop ? (req & ~gnt_q) : req;

    weighted_rr_arbiter_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i    (pick_req),
        .ptr_i    (pick_ptr),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // A zero weight still grants one beat/packet.
    assign pick_weight = weight_arr[pick_idx];
    assign load_credit = (pick_weight == '0) ? WW'(1) : pick_weight;

    assign load_w = pick_any & ((state_q == IDLE) | release_w);

    // Arbiter FSM with registered grant, credit, packet tracking and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            ptr_q      <= '0;
            credit_q   <= '0;
            pkt_open_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_w) begin
                        state_q    <= BUSY;
                        gnt_q      <= pick_onehot;
                        gnt_idx_q  <= pick_idx;
                        credit_q   <= load_credit;
                        pkt_open_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (release_w) begin
                        ptr_q <= next_ptr;
                        if (load_w) begin
                            gnt_q      <= pick_onehot;
                            gnt_idx_q  <= pick_idx;
                            credit_q   <= load_credit;
                            pkt_open_q <= 1'b0;
                        end else begin
                            state_q    <= IDLE;
                            gnt_q      <= '0;
                            gnt_idx_q  <= '0;
                            credit_q   <= '0;
                            pkt_open_q <= 1'b0;
                        end
                    end else if (beat_w) begin
                        if (credit_dec) begin
                            credit_q <= credit_q - WW'(1);
                        end
                        if (PKT_MODE != 0) begin
                            pkt_open_q <= ~g_last;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = |gnt_q;
    assign beat    = beat_w;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Scoreboard bench: a beat-mode and a packet-mode arbiter share one stimulus
// stream; a reference model pushes expected outputs per cycle and a separate
// monitor pops and compares them.
module tb_weighted_rr_arbiter;

    localparam int N  = 8;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*WW-1:0] weight;
    logic            ready;

    logic [N-1:0] gnt0, gnt1;
    logic [2:0]   idx0, idx1;
    logic         vld0, vld1, beat0, beat1;

    always #5 clk = ~clk;

    weighted_rr_arbiter #(.N(N), .WW(WW), .PKT_MODE(0)) dut_beat (
        .clk(clk), .rst(rst), .req(req), .last(last), .weight(weight), .ready(ready),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_vld(vld0), .beat(beat0)
    );

    weighted_rr_arbiter #(.N(N), .WW(WW), .PKT_MODE(1)) dut_pkt (
        .clk(clk), .rst(rst), .req(req), .last(last), .weight(weight), .ready(ready),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_vld(vld1), .beat(beat1)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [2:0]   idx;
        logic         vld;
        logic         beat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   started    = 0;

    // Reference model state per instance (0: beat mode, 1: packet mode).
    int owner  [2];
    int credit [2];
    int ptr    [2];
    bit open_p [2];
    bit known = 0;
    logic [N-1:0] prev_gnt [2];

    function automatic int eff_w(input int i);
        int v;
        v = int'(weight[i*WW +: WW]);
        return (v == 0) ? 1 : v;
    endfunction

    // First requester found scanning start, start+1, ... modulo N.
    function automatic int first_from(input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic exp_t expect_of(input int d);
        exp_t e;
        e = '0;
        if (owner[d] >= 0) begin
            e.gnt[owner[d]] = 1'b1;
            e.idx  = 3'(owner[d]);
            e.vld  = 1'b1;
            e.beat = req[owner[d]] && ready;
        end
        return e;
    endfunction

    task automatic grant_to(input int d, input int g);
        if (g >= 0) begin
            owner[d]  = g;
            credit[d] = eff_w(g);
        end else begin
            owner[d]  = -1;
            credit[d] = 0;
        end
        open_p[d] = 0;
    endtask

    // Advance one clock edge using the inputs currently applied.
    task automatic model_step(input int d, input int mode);
        int g;
        bit rel;
        if (rst) begin
            owner[d] = -1; credit[d] = 0; ptr[d] = 0; open_p[d] = 0;
            return;
        end
        if (owner[d] < 0) begin
            g = first_from(ptr[d]);
            if (g >= 0) grant_to(d, g);
            return;
        end
        g   = owner[d];
        rel = 0;
        if (req[g] && ready) begin
            if (mode == 0 || last[g]) begin
                credit[d] = credit[d] - 1;
                if (credit[d] == 0) rel = 1;
            end
            if (mode == 1) open_p[d] = !last[g];
        end
        if (!req[g] && (mode == 0 || !open_p[d])) rel = 1;
        if (rel) begin
            ptr[d] = (g + 1) % N;
            grant_to(d, first_from(ptr[d]));
        end
    endtask

    // Reference model: record what this cycle should show, then take the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (known) begin
                q0.push_back(expect_of(0));
                q1.push_back(expect_of(1));
                started = 1;
            end
            if (rst || known) begin
                model_step(0, 0);
                model_step(1, 1);
                if (rst) known = 1;
            end
        end
    end

    task automatic check(input int d, input logic [N-1:0] g, input logic [2:0] i,
                         input logic v, input logic b);
        exp_t e, a;
        a = {g, i, v, b};
        compared++;
        if (d == 0 ? q0.size() == 0 : q1.size() == 0) begin
            mismatched++;
            $display("FAIL dut%0d scoreboard_empty at %0t: got gnt=%02h", d, $time, g);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (a !== e) begin
            mismatched++;
            $display("FAIL dut%0d grant_check at %0t: got gnt=%02h idx=%0d vld=%b beat=%b, expected gnt=%02h idx=%0d vld=%b beat=%b",
                     d, $time, a.gnt, a.idx, a.vld, a.beat, e.gnt, e.idx, e.vld, e.beat);
        end else if (e.gnt != prev_gnt[d]) begin
            $display("dut%0d t=%0t grant %02h idx %0d", d, $time, e.gnt, e.idx);
        end
        prev_gnt[d] = e.gnt;
    endtask

    // Monitor: compares DUT outputs mid-cycle, away from both clock edges.
    initial begin
        prev_gnt[0] = '0;
        prev_gnt[1] = '0;
        forever begin
            @(negedge clk);
            #2;
            if (started) begin
                check(0, gnt0, idx0, vld0, beat0);
                check(1, gnt1, idx1, vld1, beat1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int i, input int v);
        weight[i*WW +: WW] = WW'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        last   = '1;
        ready  = 1'b1;
        weight = {N{4'h1}};
        tick();
        tick();
        rst = 1'b0;

        // Two requesters, weight 1: strict alternation.
        req = 8'h81;
        repeat (8) tick();

        // Weight 3 vs 1.
        req = '0;
        do_reset();
        set_w(0, 3);
        set_w(1, 1);
        req = 8'h03;
        repeat (12) tick();

        // Backpressure holds grant and credit.
        req = '0;
        do_reset();
        weight = {N{4'h1}};
        set_w(2, 4);
        set_w(3, 2);
        req = 8'h04;
        tick();
        ready = 1'b0;
        repeat (5) tick();
        ready = 1'b1;
        req   = 8'h0C;
        repeat (8) tick();

        // Request drop mid-packet.
        req  = '0;
        do_reset();
        last = '0;
        req  = 8'h04;
        tick();
        tick();
        req = 8'h02;
        repeat (2) tick();
        req  = 8'h06;
        last = 8'h04;
        tick();
        last = '0;
        repeat (4) tick();

        // Lone requester re-grants itself, then drops.
        req  = '0;
        last = '1;
        do_reset();
        set_w(5, 2);
        req = 8'h20;
        repeat (7) tick();
        req = '0;
        repeat (3) tick();

        // Reset in the middle of a tenure.
        set_w(4, 5);
        req = 8'h10;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        repeat (4) tick();

        // Weight extremes: 0 behaves as 1, 15 is the longest tenure.
        set_w(6, 0);
        set_w(7, 15);
        req = 8'hC0;
        repeat (24) tick();

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            last  = N'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            if ((c % 64) == 0) weight = N*WW'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        req = '0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
